// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG MCU zigzag serializer: zigzag coordinate
// tables, scan length and the serializer FSM state encoding.
package jpeg_pkg;

    localparam int ZZ_LEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } zz_state_t;

    // Row of the coefficient emitted at zigzag position k (index 0 is leftmost)
    localparam logic [0:ZZ_LEN-1][2:0] ZZ_ROW = {
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
        3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };

    // Column of the coefficient emitted at zigzag position k
    localparam logic [0:ZZ_LEN-1][2:0] ZZ_COL = {
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };

endpackage

// File: rtl/zz_block_reg.sv
// One MCU-sized coefficient block register with its end-of-image flag and a
// zigzag-indexed read mux. Data is not reset; validity is tracked by the owner.
module zz_block_reg
    import jpeg_pkg::*;
#(
    parameter int MCU_SIZE  = 8,
    parameter int BIT_WIDTH = 12
) (
    input  logic                                              clk,
    input  logic                                              load,
    input  logic [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0]  din,
    input  logic                                              last_in,
    input  logic [5:0]                                        index,
    output logic [BIT_WIDTH-1:0]                              data,
    output logic                                              last
);

    logic [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0] blk;

    // Capture a whole block and its last-of-image flag when loaded
    always_ff @(posedge clk) begin
        if (load) begin
            blk  <= din;
            last <= last_in;
        end
    end

    assign data = blk[ZZ_ROW[index]][ZZ_COL[index]];

endmodule

// File: rtl/mcu_zigzag_serializer.sv
// MCU zigzag serializer: pops one 8x8 coefficient block from the MCU FIFO and
// streams it in JPEG zigzag order over a valid/ready interface.
// Optional build macro ZZ_PREFETCH_EN adds a second (shadow) bank so the next
// block is fetched while the current one streams, removing the inter-block
// bubble. Banks ping-pong: "moving shadow to active" is a bank-select flip.
module mcu_zigzag_serializer
    import jpeg_pkg::*;
#(
    parameter int MCU_SIZE  = 8,
    parameter int BIT_WIDTH = 12
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              fifo_empty,
    output logic                                              fifo_re,
    input  logic [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0]  mcu_din,
    input  logic                                              mcu_last,
    input  logic                                              mcu_valid,
    output logic [BIT_WIDTH-1:0]                              o_data,
    output logic [5:0]                                        o_index,
    output logic                                              o_valid,
    input  logic                                              i_ready,
    output logic                                              o_eob,
    output logic                                              o_last,
    output logic                                              busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_SEND = SEND;

    if (MCU_SIZE != 8) begin : g_bad_mcu_size
        $error("mcu_zigzag_serializer: MCU_SIZE must be 8 (zigzag table is fixed)");
    end

    logic [1:0]           state;
    logic [5:0]           k;
    logic                 beat;
    logic                 blk_end;
    logic                 cap_window;
    logic                 cap;
    logic [BIT_WIDTH-1:0] data0;
    logic                 last0;

    assign beat    = (state == ST_SEND) && i_ready;
    assign blk_end = beat && (k == 6'd63);
    assign cap     = mcu_valid && cap_window;
    assign o_valid = (state == ST_SEND);
    assign o_index = k;
    assign o_eob   = o_valid && (k == 6'd63);

`ifdef ZZ_PREFETCH_EN
    logic                 act_sel;
    logic                 shadow_valid;
    logic                 pend;
    logic                 load_bank;
    logic [BIT_WIDTH-1:0] data1;
    logic                 last1;

    assign cap_window = (state == ST_REQ) || ((state == ST_SEND) && pend);
    assign fifo_re    = !rst && !fifo_empty &&
                        ((state == ST_IDLE) || ((state == ST_SEND) && !shadow_valid && !pend));
    // During SEND new data lands in the idle bank, except when the shadow is
    // handed over this same cycle: then the bank being freed takes it.
    assign load_bank  = ((state == ST_SEND) && !(blk_end && shadow_valid)) ? ~act_sel : act_sel;

    zz_block_reg #(.MCU_SIZE(MCU_SIZE), .BIT_WIDTH(BIT_WIDTH)) u_bank0 (
        .clk(clk), .load(cap && !load_bank), .din(mcu_din), .last_in(mcu_last),
        .index(k), .data(data0), .last(last0)
    );
    zz_block_reg #(.MCU_SIZE(MCU_SIZE), .BIT_WIDTH(BIT_WIDTH)) u_bank1 (
        .clk(clk), .load(cap && load_bank), .din(mcu_din), .last_in(mcu_last),
        .index(k), .data(data1), .last(last1)
    );

    assign o_data = act_sel ? data1 : data0;
    assign o_last = o_eob && (act_sel ? last1 : last0);
    assign busy   = (state != ST_IDLE) || shadow_valid;

    // Sequencing FSM, zigzag counter, bank select and prefetch bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            k            <= 6'd0;
            act_sel      <= 1'b0;
            shadow_valid <= 1'b0;
            pend         <= 1'b0;
        end else begin
            if (cap)
                pend <= 1'b0;
            else if (fifo_re && (state == ST_SEND))
                pend <= 1'b1;

            case (state)
                ST_IDLE: if (fifo_re) state <= ST_REQ;
                ST_REQ: begin
                    if (cap) begin
                        state <= ST_SEND;
                        k     <= 6'd0;
                    end
                end
                ST_SEND: begin
                    if (blk_end) begin
                        k <= 6'd0;
                        if (shadow_valid || cap) begin
                            act_sel      <= ~act_sel;
                            shadow_valid <= shadow_valid && cap;
                        end else if (pend || fifo_re) begin
                            state <= ST_REQ;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (beat) k <= k + 6'd1;
                        if (cap) shadow_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign cap_window = (state == ST_REQ);
    assign fifo_re    = !rst && !fifo_empty && (state == ST_IDLE);

    zz_block_reg #(.MCU_SIZE(MCU_SIZE), .BIT_WIDTH(BIT_WIDTH)) u_bank0 (
        .clk(clk), .load(cap), .din(mcu_din), .last_in(mcu_last),
        .index(k), .data(data0), .last(last0)
    );

    assign o_data = data0;
    assign o_last = o_eob && last0;
    assign busy   = (state != ST_IDLE);

    // Sequencing FSM and zigzag counter for the single-bank build
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: if (fifo_re) state <= ST_REQ;
                ST_REQ: begin
                    if (cap) begin
                        state <= ST_SEND;
                        k     <= 6'd0;
                    end
                end
                ST_SEND: begin
                    if (blk_end) begin
                        state <= ST_IDLE;
                        k     <= 6'd0;
                    end else if (beat) begin
                        k <= k + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

    // FIFO data arriving while no request is outstanding is a protocol error
    a_mcu_valid_window: assert property (@(posedge clk) disable iff (rst) mcu_valid |-> cap_window);

endmodule

// File: tb/tb_mcu_zigzag_serializer.sv
// Self-checking bench for mcu_zigzag_serializer: behavioural MCU FIFO, an
// independently derived zigzag walk, and a scoreboard of expected beats.
module tb_mcu_zigzag_serializer;

    typedef logic [0:7][0:7][11:0] blk_t;
    typedef struct {
        logic [11:0] data;
        logic [5:0]  index;
        logic        eob;
        logic        last;
    } exp_t;

`ifdef ZZ_PREFETCH_EN
    localparam int BLOCK_PERIOD = 64;
`else
    localparam int BLOCK_PERIOD = 66;
`endif

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_re;
    blk_t        mcu_din;
    logic        mcu_last;
    logic        mcu_valid;
    logic [11:0] o_data;
    logic [5:0]  o_index;
    logic        o_valid;
    logic        i_ready;
    logic        o_eob;
    logic        o_last;
    logic        busy;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   re_cnt;
    int   valid_cnt;
    int   zr [64];
    int   zc [64];
    blk_t fifo_q [$];
    logic last_q [$];
    exp_t exp_q  [$];
    int   eob_cyc [$];

    mcu_zigzag_serializer #(.MCU_SIZE(8), .BIT_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .mcu_din(mcu_din), .mcu_last(mcu_last), .mcu_valid(mcu_valid),
        .o_data(o_data), .o_index(o_index), .o_valid(o_valid), .i_ready(i_ready),
        .o_eob(o_eob), .o_last(o_last), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Zigzag walk built from anti-diagonals, independent of the RTL tables
    task automatic buildOrder();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 8) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zr[n] = r; zc[n] = s - r; n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zr[n] = r; zc[n] = s - r; n++; end
            end
        end
    endtask

    function automatic blk_t makeBlock(input bit ramp);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = ramp ? 12'(r * 8 + c) : 12'($urandom_range(0, 4095));
        return b;
    endfunction

    // Queue a block in the FIFO model and its 64 expected beats
    task automatic applyStimulus(input blk_t b, input logic lst);
        exp_t e;
        fifo_q.push_back(b);
        last_q.push_back(lst);
        fifo_empty = 1'b0;
        for (int n = 0; n < 64; n++) begin
            e.data  = b[zr[n]][zc[n]];
            e.index = 6'(n);
            e.eob   = (n == 63);
            e.last  = lst && (n == 63);
            exp_q.push_back(e);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_remaining", exp_q.size(), 0);
    endtask

    // MCU FIFO model: a read seen this cycle returns data the next cycle
    initial begin : fifo_model
        mcu_valid = 1'b0;
        mcu_last  = 1'b0;
        mcu_din   = '0;
        forever begin
            @(negedge clk);
            if (fifo_re && !rst && fifo_q.size() > 0) begin
                @(posedge clk);
                #1;
                mcu_din    = fifo_q.pop_front();
                mcu_last   = last_q.pop_front();
                fifo_empty = (fifo_q.size() == 0);
                mcu_valid  = 1'b1;
                @(posedge clk);
                #1;
                mcu_valid  = 1'b0;
            end
        end
    end

    // Output monitor: every valid cycle must present the scoreboard head
    always @(negedge clk) begin
        if (fifo_re) re_cnt++;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", o_valid, 1'b0);
            end else begin
                checkOutput("o_data",  o_data,  exp_q[0].data);
                checkOutput("o_index", o_index, exp_q[0].index);
                checkOutput("o_eob",   o_eob,   exp_q[0].eob);
                checkOutput("o_last",  o_last,  exp_q[0].last);
                if (i_ready) begin
                    valid_cnt++;
                    if (exp_q[0].eob) eob_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        int t0;
        int n;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        re_cnt      = 0;
        valid_cnt   = 0;
        buildOrder();
        rst        = 1'b1;
        i_ready    = 1'b1;
        fifo_empty = 1'b0;

        // Reset: outputs idle and fifo_re gated by rst even with FIFO non-empty
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_fifo_re", fifo_re, 1'b0);
        checkOutput("rst_o_valid", o_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_o_index", o_index, 6'd0);
        checkOutput("rst_o_eob", o_eob, 1'b0);
        @(posedge clk);
        #1;
        fifo_empty = 1'b1;
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Ramp block, ready held high: latency and 64-beat span
        applyStimulus(makeBlock(1'b1), 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!fifo_re && n < 10);
        checkOutput("fifo_re_seen", fifo_re, 1'b1);
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_valid && n < 10);
        checkOutput("first_valid_latency", cyc - t0, 2);
        eob_cyc.delete();
        waitDrain(200);
        checkOutput("eob_count_blk1", eob_cyc.size(), 1);
        if (eob_cyc.size() > 0) checkOutput("block_span", eob_cyc[0] - t0, 65);
        repeat (3) @(posedge clk);
        #1;

        // Same block with i_ready toggling every cycle
        applyStimulus(makeBlock(1'b1), 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            i_ready = ~i_ready;
            n++;
        end
        checkOutput("toggle_drain", exp_q.size(), 0);
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Two random blocks, second marked last of image
        eob_cyc.delete();
        applyStimulus(makeBlock(1'b0), 1'b0);
        applyStimulus(makeBlock(1'b0), 1'b1);
        waitDrain(400);
        checkOutput("eob_count_two", eob_cyc.size(), 2);
        if (eob_cyc.size() == 2) checkOutput("block_period_two", eob_cyc[1] - eob_cyc[0], BLOCK_PERIOD);
        repeat (3) @(posedge clk);

        // Empty FIFO: nothing happens for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("empty_fifo_re", fifo_re, 1'b0);
            checkOutput("empty_o_valid", o_valid, 1'b0);
            checkOutput("empty_busy", busy, 1'b0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a block, then a fresh block from coefficient 0
        applyStimulus(makeBlock(1'b0), 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(o_valid && o_index == 6'd30) && n < 100);
        checkOutput("reached_beat30", o_index, 6'd30);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_o_valid", o_valid, 1'b0);
        checkOutput("midrst_o_index", o_index, 6'd0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_o_eob", o_eob, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(makeBlock(1'b0), 1'b1);
        waitDrain(200);
        repeat (3) @(posedge clk);
        #1;

        // Three queued blocks: one read pulse each, back-to-back streaming
        re_cnt    = 0;
        valid_cnt = 0;
        eob_cyc.delete();
        applyStimulus(makeBlock(1'b0), 1'b0);
        applyStimulus(makeBlock(1'b0), 1'b0);
        applyStimulus(makeBlock(1'b0), 1'b1);
        waitDrain(600);
        repeat (3) @(posedge clk);
        checkOutput("three_re_pulses", re_cnt, 3);
        checkOutput("three_valid_beats", valid_cnt, 192);
        checkOutput("three_eob_count", eob_cyc.size(), 3);
        if (eob_cyc.size() == 3) begin
            checkOutput("three_period_a", eob_cyc[1] - eob_cyc[0], BLOCK_PERIOD);
            checkOutput("three_period_b", eob_cyc[2] - eob_cyc[1], BLOCK_PERIOD);
        end
        @(negedge clk);
        checkOutput("final_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
